// File: rtl/reg_file_8x16_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_pkg
//  Brief    : Shared widths, register count and dump state encoding for the
//             8x16 register file and its serial dump engine.
//  Revision : 1.0  initial release
// ============================================================================
package reg_file_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  // Dump engine states; 2-bit encoding with one spare code.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dump_state_e;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file_8x16_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_if
//  Brief    : Bus bundle for the register file: one write port, two read
//             ports and the serial dump handshake.
//  Revision : 1.0  initial release
// ============================================================================
interface reg_file_if #(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
);

  // Write port
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // Read ports
  logic [ADDR_W-1:0] raddr_a;
  logic [DATA_W-1:0] rdata_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_b;

  // Serial dump
  logic              dump_req;
  logic              dump_busy;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_done;

  // Requester side (drives writes, read addresses and dump control)
  modport master (
    output we, waddr, wdata, raddr_a, raddr_b, dump_req, dump_ready,
    input  rdata_a, rdata_b, dump_busy, dump_valid, dump_addr, dump_data,
           dump_done
  );

  // Register file side
  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b, dump_req, dump_ready,
    output rdata_a, rdata_b, dump_busy, dump_valid, dump_addr, dump_data,
           dump_done
  );

endinterface : reg_file_if
`default_nettype wire

// File: rtl/reg_file_8x16_dump_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : reg_dump_fsm
//  Brief    : Serial readback engine. Walks indices 0..NUM_REGS-1 over a
//             valid/ready beat handshake, capturing each beat's payload into
//             a register at the edge the beat is loaded, then pulses done.
//  Revision : 1.0  initial release
// ============================================================================
module reg_dump_fsm #(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              dump_req_i,
  input  wire logic              dump_ready_i,
  // Index whose post-edge value must be captured, and that value
  output      logic [ADDR_W-1:0] load_idx_o,
  input  wire logic [DATA_W-1:0] load_data_i,
  output      logic              dump_busy_o,
  output      logic              dump_valid_o,
  output      logic [ADDR_W-1:0] dump_addr_o,
  output      logic [DATA_W-1:0] dump_data_o,
  output      logic              dump_done_o
);

  import reg_file_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q,   idx_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [ADDR_W-1:0] w_load_idx;

  // State, beat index and captured payload; cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic; payload only reloads when a new beat is loaded, so it
  // holds through backpressure regardless of later register writes.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    data_d     = data_q;
    w_load_idx = '0;
    case (state_q)
      IDLE: begin
        if (dump_req_i) begin
          state_d = SEND;
          idx_d   = '0;
          data_d  = load_data_i;
        end
      end
      SEND: begin
        w_load_idx = idx_q + ADDR_W'(1);
        if (dump_ready_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d  = w_load_idx;
            data_d = load_data_i;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign load_idx_o   = w_load_idx;
  assign dump_valid_o = (state_q == SEND);
  assign dump_done_o  = (state_q == DONE);
  assign dump_busy_o  = (state_q == SEND) || (state_q == DONE);
  assign dump_addr_o  = idx_q;
  assign dump_data_o  = data_q;

endmodule : reg_dump_fsm
`default_nettype wire

// File: rtl/reg_file_8x16.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_8x16
//  Brief    : 8-entry register file with hardwired-zero index 0, two
//             combinational read ports with write bypass, and a serial dump
//             engine that streams every register out over valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module reg_file_8x16 #(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
  input wire logic   clk,
  input wire logic   rst_n,
  reg_file_if.slave  bus
);

  import reg_file_pkg::*;

  localparam int N_REGS  = 2 ** ADDR_W;
  localparam int N_PORTS = 3;  // read A, read B, dump capture

  logic [DATA_W-1:0] regs_q [N_REGS];
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_raddr [N_PORTS];
  logic [DATA_W-1:0] w_rdata [N_PORTS];
  logic [ADDR_W-1:0] w_dump_idx;

  // Index 0 is never written, so it stays at its reset value of zero.
  assign w_wr_en = bus.we && (bus.waddr != '0);

  // Storage: asynchronous clear, one write per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (w_wr_en) begin
      regs_q[bus.waddr] <= bus.wdata;
    end
  end

  assign w_raddr[0] = bus.raddr_a;
  assign w_raddr[1] = bus.raddr_b;
  assign w_raddr[2] = w_dump_idx;

  // Every read path sees the value the register will hold after this edge:
  // zero for index 0, the in-flight write data on an address match, else
  // the stored value. The dump capture uses the same path so a write on the
  // load edge lands in the captured beat.
  for (genvar p = 0; p < N_PORTS; p++) begin : g_rd
    assign w_rdata[p] = (w_raddr[p] == '0)                       ? '0        :
                        (w_wr_en && (bus.waddr == w_raddr[p]))   ? bus.wdata :
                                                                   regs_q[w_raddr[p]];
  end

  assign bus.rdata_a = w_rdata[0];
  assign bus.rdata_b = w_rdata[1];

  reg_dump_fsm #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_dump (
    .clk          (clk),
    .rst_n        (rst_n),
    .dump_req_i   (bus.dump_req),
    .dump_ready_i (bus.dump_ready),
    .load_idx_o   (w_dump_idx),
    .load_data_i  (w_rdata[2]),
    .dump_busy_o  (bus.dump_busy),
    .dump_valid_o (bus.dump_valid),
    .dump_addr_o  (bus.dump_addr),
    .dump_data_o  (bus.dump_data),
    .dump_done_o  (bus.dump_done)
  );

endmodule : reg_file_8x16
`default_nettype wire

// File: tb/tb_reg_file_8x16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_8x16
//  Brief    : Directed bench for reg_file_8x16. Dump beats are predicted into
//             a queue at issue time and checked by an independent monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_file_8x16;

  typedef struct {
    bit          is_done;
    logic [2:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];
  int   ncyc;

  reg_file_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  reg_file_8x16 #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // Monitor: compare every presented beat against the queue head; pop on
  // handshake, so a stalled beat is re-checked each cycle for stability.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.dump_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected actual=addr %0d data %h required=no beat",
                   bus.dump_addr, bus.dump_data);
        end else begin
          e = sb[0];
          if (e.is_done || bus.dump_addr !== e.addr || bus.dump_data !== e.data) begin
            errors++;
            $display("FAIL beat actual=addr %0d data %h required=addr %0d data %h done %0d",
                     bus.dump_addr, bus.dump_data, e.addr, e.data, e.is_done);
          end
          if (bus.dump_ready) sb.delete(0);
        end
      end
      if (bus.dump_done) begin
        checks++;
        if (sb.size() == 0 || !sb[0].is_done) begin
          errors++;
          $display("FAIL done_unexpected actual=dump_done 1 required=no done");
        end else begin
          sb.delete(0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_beat(input logic [2:0] a, input logic [15:0] d);
    exp_t e;
    e.is_done = 1'b0;
    e.addr    = a;
    e.data    = d;
    sb.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.addr    = '0;
    e.data    = '0;
    sb.push_back(e);
  endtask

  // Tick until the monitor has consumed everything, bounded by max_cyc.
  task automatic wait_drain(input int max_cyc, output int used);
    used = 0;
    while (sb.size() != 0 && used < max_cyc) begin
      tick();
      used++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic start_dump();
    bus.dump_req = 1'b1;
    tick();
    bus.dump_req = 1'b0;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.we         = 1'b0;
    bus.waddr      = '0;
    bus.wdata      = '0;
    bus.raddr_a    = '0;
    bus.raddr_b    = '0;
    bus.dump_req   = 1'b0;
    bus.dump_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_valid", 32'(bus.dump_valid), 32'h0);
    chk("rst_busy",  32'(bus.dump_busy),  32'h0);
    chk("rst_done",  32'(bus.dump_done),  32'h0);
    chk("rst_data",  32'(bus.dump_data),  32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.raddr_a = 3'(i);
      #1;
      chk("rst_reg", 32'(bus.rdata_a), 32'h0);
    end

    // Write r3, read both ports next cycle
    bus.we = 1'b1; bus.waddr = 3'd3; bus.wdata = 16'h1234;
    tick();
    bus.we = 1'b0; bus.raddr_a = 3'd3; bus.raddr_b = 3'd3;
    #1;
    chk("r3_a", 32'(bus.rdata_a), 32'h1234);
    chk("r3_b", 32'(bus.rdata_b), 32'h1234);

    // Same-cycle bypass on port A; port B on another index is unaffected
    bus.we = 1'b1; bus.waddr = 3'd5; bus.wdata = 16'hBEEF;
    bus.raddr_a = 3'd5; bus.raddr_b = 3'd4;
    #1;
    chk("bypass_a", 32'(bus.rdata_a), 32'hBEEF);
    chk("nobypass_b", 32'(bus.rdata_b), 32'h0);
    tick();
    bus.we = 1'b0;
    #1;
    chk("r5_after", 32'(bus.rdata_a), 32'hBEEF);

    // Writes to r0 are dropped, including on the bypass path
    bus.we = 1'b1; bus.waddr = 3'd0; bus.wdata = 16'hFFFF;
    bus.raddr_a = 3'd0;
    #1;
    chk("r0_bypass", 32'(bus.rdata_a), 32'h0);
    tick();
    bus.we = 1'b0;
    #1;
    chk("r0_after", 32'(bus.rdata_a), 32'h0);

    // Preload r1..r7 = 0x1111..0x7777
    for (int i = 1; i < 8; i++) begin
      bus.we = 1'b1; bus.waddr = 3'(i); bus.wdata = 16'(i * 16'h1111);
      tick();
    end
    bus.we = 1'b0;
    bus.raddr_a = 3'd7; bus.raddr_b = 3'd3;
    #1;
    chk("pre_r7", 32'(bus.rdata_a), 32'h7777);
    chk("pre_r3", 32'(bus.rdata_b), 32'h3333);

    // Dump 1: full rate
    push_beat(3'd0, 16'h0000); push_beat(3'd1, 16'h1111);
    push_beat(3'd2, 16'h2222); push_beat(3'd3, 16'h3333);
    push_beat(3'd4, 16'h4444); push_beat(3'd5, 16'h5555);
    push_beat(3'd6, 16'h6666); push_beat(3'd7, 16'h7777);
    push_done();
    bus.dump_ready = 1'b1;
    start_dump();
    wait_drain(30, ncyc);
    chk("dump1_cycles", 32'(ncyc), 32'd9);
    chk("dump1_idle", 32'(bus.dump_busy), 32'h0);

    // Dump 2: stall beat 2 for three cycles while r2 is rewritten
    push_beat(3'd0, 16'h0000); push_beat(3'd1, 16'h1111);
    push_beat(3'd2, 16'h2222); push_beat(3'd3, 16'h3333);
    push_beat(3'd4, 16'h4444); push_beat(3'd5, 16'h5555);
    push_beat(3'd6, 16'h6666); push_beat(3'd7, 16'h7777);
    push_done();
    start_dump();
    tick();
    tick();
    bus.dump_ready = 1'b0;
    bus.we = 1'b1; bus.waddr = 3'd2; bus.wdata = 16'hAAAA;
    tick();
    bus.we = 1'b0;
    bus.raddr_a = 3'd2;
    #1;
    chk("r2_during_dump", 32'(bus.rdata_a), 32'hAAAA);
    tick();
    tick();
    chk("stall_addr", 32'(bus.dump_addr), 32'd2);
    bus.dump_ready = 1'b1;
    wait_drain(30, ncyc);

    // Dump 3: shows the new r2
    push_beat(3'd0, 16'h0000); push_beat(3'd1, 16'h1111);
    push_beat(3'd2, 16'hAAAA); push_beat(3'd3, 16'h3333);
    push_beat(3'd4, 16'h4444); push_beat(3'd5, 16'h5555);
    push_beat(3'd6, 16'h6666); push_beat(3'd7, 16'h7777);
    push_done();
    start_dump();
    wait_drain(30, ncyc);

    // Dump 4: reset mid-clock while beat 4 is presented
    push_beat(3'd0, 16'h0000); push_beat(3'd1, 16'h1111);
    push_beat(3'd2, 16'hAAAA); push_beat(3'd3, 16'h3333);
    push_beat(3'd4, 16'h4444);
    start_dump();
    tick(); tick(); tick(); tick();
    bus.dump_ready = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.dump_valid), 32'h0);
    chk("arst_busy",  32'(bus.dump_busy),  32'h0);
    chk("arst_done",  32'(bus.dump_done),  32'h0);
    chk("arst_addr",  32'(bus.dump_addr),  32'h0);
    chk("arst_data",  32'(bus.dump_data),  32'h0);
    sb.delete();
    for (int i = 0; i < 8; i++) begin
      bus.raddr_a = 3'(i);
      bus.raddr_b = 3'(7 - i);
      #1;
      chk("arst_reg_a", 32'(bus.rdata_a), 32'h0);
      chk("arst_reg_b", 32'(bus.rdata_b), 32'h0);
    end
    tick();
    rst_n = 1'b1;
    bus.dump_ready = 1'b1;
    tick();
    chk("post_rst_done", 32'(bus.dump_done), 32'h0);

    // First dump after reset starts at beat 0 with all-zero data
    for (int i = 0; i < 8; i++) push_beat(3'(i), 16'h0000);
    push_done();
    start_dump();
    wait_drain(30, ncyc);
    chk("dump5_cycles", 32'(ncyc), 32'd9);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_file_8x16
`default_nettype wire

// File: doc/reg_file_8x16.md
REG_FILE_8X16 -- requirements
Module: reg_file_8x16

Interface
REQ-001 SHALL have parameter DATA_W, default 16: register and data width.
REQ-002 SHALL have parameter ADDR_W, default 3: register index width, NUM_REGS = 2**ADDR_W (8).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock for all state.
REQ-004 SHALL have rst_n input 1: asynchronous active-low reset.
REQ-005 SHALL have we input 1: write enable.
REQ-006 SHALL have waddr input ADDR_W: write index.
REQ-007 SHALL have wdata input DATA_W: write data.
REQ-008 SHALL have raddr_a input ADDR_W and rdata_a output DATA_W: read port A.
REQ-009 SHALL have raddr_b input ADDR_W and rdata_b output DATA_W: read port B.
REQ-010 SHALL have dump_req input 1: request a full serial readback of all registers.
REQ-011 SHALL have dump_busy output 1: dump in progress, SEND or DONE state.
REQ-012 SHALL have dump_valid output 1 and dump_ready input 1: beat handshake.
REQ-013 SHALL have dump_addr output ADDR_W and dump_data output DATA_W: beat index and payload.
REQ-014 SHALL have dump_done output 1: single-cycle pulse after the last beat.

Function
REQ-015 Write: on a rising clk edge with we=1 and waddr!=0, reg[waddr] SHALL take wdata; writes to index 0 SHALL be discarded.
REQ-016 Index 0 SHALL always read as 0 on every read path.
REQ-017 Read ports SHALL be combinational, with zero-cycle latency from raddr_x to rdata_x.
REQ-018 Bypass: when we=1, waddr==raddr_x and waddr!=0, rdata_x SHALL equal wdata in the same cycle.
REQ-019 Simultaneous reads of the same index on A and B SHALL return identical data.
REQ-020 Dump FSM SHALL have exactly three states: IDLE, SEND, DONE.
REQ-021 In IDLE, dump_req=1 at a clock edge SHALL move the FSM to SEND and load beat index 0.
REQ-022 In SEND, dump_valid SHALL be 1 and dump_addr SHALL equal the beat index.
REQ-023 dump_data SHALL be registered; it SHALL equal reg[k] as updated by the edge at which beat k is loaded, including a write at that edge.
REQ-024 While dump_valid=1 and dump_ready=0, dump_addr and dump_data SHALL hold stable; writes to reg[k] after the load SHALL NOT alter dump_data.
REQ-025 A handshake (valid&ready at an edge) on beat k<NUM_REGS-1 SHALL load beat k+1 at that edge, sustaining one beat per cycle.
REQ-026 A handshake on beat NUM_REGS-1 SHALL move the FSM to DONE, with no index wrap.
REQ-027 DONE SHALL last exactly one cycle with dump_done=1 and dump_valid=0, then return to IDLE.
REQ-028 dump_req SHALL be ignored while dump_busy=1; a dump_req held high in IDLE after DONE SHALL start a new dump.
REQ-029 Beat 0 SHALL carry dump_data=0.
REQ-030 Register writes and read ports SHALL operate normally during a dump.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately clear all registers to 0.
REQ-032 Asserting rst_n=0 SHALL put the FSM in IDLE and set dump_valid, dump_done, dump_busy, dump_addr and dump_data to 0, independent of clk.
REQ-033 Reset mid-dump SHALL abort the dump with no dump_done pulse.
REQ-034 The first dump_req after rst_n deassertion SHALL start at beat 0.

Structure
REQ-035 A shared package reg_file_pkg SHALL hold DATA_W, ADDR_W, NUM_REGS and the dump state enum (IDLE, SEND, DONE).
REQ-036 The dump FSM and its beat index/data registers SHALL be one sub-module, reg_dump_fsm; storage, bypass and read muxes SHALL stay in reg_file_8x16.

Verification
REQ-037 Bench SHALL cover: write 0x1234 to r3, read A=3 and B=3 next cycle -> both return 0x1234.
REQ-038 Bench SHALL cover: we=1, waddr=5, wdata=0xBEEF with raddr_a=5 in the same cycle -> rdata_a=0xBEEF before the edge.
REQ-039 Bench SHALL cover: write 0xFFFF to r0, read A=0 -> 0x0000.
REQ-040 Bench SHALL cover: preload r1..r7 with 0x1111..0x7777, pulse dump_req, ready held 1 -> 8 consecutive beats with addr 0..7 and data 0,0x1111..0x7777, then one dump_done cycle.
REQ-041 Bench SHALL cover: ready=0 for 3 cycles on beat 2 while r2 is written to 0xAAAA -> beat 2 holds 0x2222, and the second dump shows 0xAAAA.
REQ-042 Bench SHALL cover: rst_n pulsed low mid-clock during beat 4 -> outputs drop to 0 asynchronously, no dump_done, all registers read 0.
